// File: rtl/mem_responder.sv
// Word-addressed 16-bit data memory answering req/ready requests after WAIT_CYCLES wait states.
// Optional feature: define MEM_ERR_EN to flag accesses whose upper address bits are nonzero.
module mem_responder #(
  parameter int unsigned AW_INT      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << AW_INT;

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (AW_INT < 1 || AW_INT > 16) begin : g_bad_aw
    $error("mem_responder: AW_INT must be in 1..16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            ready_q;
  logic            busy_q;
  logic            err_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            op_we;
  logic [DW-1:0]   op_addr;
  logic [DW-1:0]   op_wdata;
  logic [AW_INT-1:0] op_idx;
  logic            accept;
  logic            enter_resp;
  logic            addr_err;

  // With zero wait states the accept edge is also the RESP entry edge, so use live inputs.
  always_comb begin
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      op_we    = mem_we;
      op_addr  = mem_addr;
      op_wdata = mem_wdata;
    end
  end

  assign op_idx     = op_addr[AW_INT-1:0];
  assign accept     = (state_q == S_IDLE) && mem_req;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == CW'(1)));

`ifdef MEM_ERR_EN
  assign addr_err = (op_addr >> AW_INT) != DW'(0);
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |(op_addr >> AW_INT);
  assign addr_err       = 1'b0;
`endif

  // Storage array: not reset; a reset in the same cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (proc_rst && enter_resp && op_we && !addr_err) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!proc_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= (state_q == S_RESP);
      err_q   <= (state_q == S_RESP) && addr_err;
      busy_q  <= accept || (state_q != S_IDLE);
      if (enter_resp && !op_we) begin
        rdata_q <= addr_err ? DW'(0) : mem_q[op_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (mem_req) begin
            we_q    <= mem_we;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            cnt_q   <= CW'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign mem_err   = err_q;

endmodule
